// File: rtl/riscv_lsu_pkg.sv
// Shared LSU types: LDST size codes, FSM states and the access legality rule.
// No logic of its own; imported by the LSU top and its load aligner.
package riscv_lsu_pkg;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        WAIT_RVALID
    } lsu_state_e;

    // Unknown size codes (3, 6, 7) are treated as faults, not as word accesses.
    function automatic logic access_err(input logic [2:0] size, input logic [1:0] off);
        case (size)
            LDST_B, LDST_BU: access_err = 1'b0;
            LDST_H, LDST_HU: access_err = off[0];
            LDST_W:          access_err = (off != 2'b00);
            default:         access_err = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/riscv_lsu_rdata_align.sv
// Load extraction: picks the byte/halfword at the given offset and extends it.
// Purely combinational, zero latency; no flow control.
module riscv_lsu_rdata_align
    import riscv_lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  size_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (size_i)
            LDST_B:  data_o = {{24{byte_sel[7]}}, byte_sel};
            LDST_BU: data_o = {24'b0, byte_sel};
            LDST_H:  data_o = {{16{half_sel[15]}}, half_sel};
            LDST_HU: data_o = {16'b0, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: issues core accesses on the data bus, aligns loads, flags faults.
// Latency 2 cycles minimum (gnt in issue cycle, rvalid next); stalls the core until rvalid.
module riscv_lsu
    import riscv_lsu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_data_i,
    output logic [31:0] lsu_data_o,
    output logic        lsu_stall_req_o,
    output logic        lsu_err_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i
);

    lsu_state_e state_q, state_d;
    logic [1:0] offset_q, offset_d;
    logic [2:0] size_q, size_d;
    logic       bad_access;
    logic       issue;
    logic       done;

    always_comb begin
        bad_access = access_err(lsu_size_i, lsu_addr_i[1:0]);
        done       = (state_q == WAIT_RVALID) && data_rvalid_i;

        lsu_err_o  = !rst_i && lsu_req_i && bad_access && (state_q == IDLE);
        data_req_o = !rst_i && (((state_q == IDLE) && lsu_req_i && !bad_access)
                                || (state_q == WAIT_GNT));
        issue      = data_req_o && data_gnt_i;

        // The core keeps its request asserted through reset, so it stays held.
        lsu_stall_req_o = rst_i ? lsu_req_i : (lsu_req_i && !bad_access && !done);

        data_we_o   = lsu_we_i;
        data_addr_o = {lsu_addr_i[31:2], 2'b00};
        case (lsu_size_i)
            LDST_B, LDST_BU: begin
                data_be_o    = 4'b0001 << lsu_addr_i[1:0];
                data_wdata_o = {4{lsu_data_i[7:0]}};
            end
            LDST_H, LDST_HU: begin
                data_be_o    = 4'b0011 << {lsu_addr_i[1], 1'b0};
                data_wdata_o = {2{lsu_data_i[15:0]}};
            end
            default: begin
                data_be_o    = 4'b1111;
                data_wdata_o = lsu_data_i;
            end
        endcase

        offset_d = issue ? lsu_addr_i[1:0] : offset_q;
        size_d   = issue ? lsu_size_i : size_q;

        state_d = state_q;
        case (state_q)
            IDLE:        if (data_req_o) state_d = data_gnt_i ? WAIT_RVALID : WAIT_GNT;
            WAIT_GNT:    if (data_gnt_i) state_d = WAIT_RVALID;
            WAIT_RVALID: if (data_rvalid_i) state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            offset_q <= 2'b00;
            size_q   <= LDST_B;
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
            size_q   <= size_d;
        end
    end

    riscv_lsu_rdata_align u_rdata_align (
        .rdata_i  (data_rdata_i),
        .offset_i (offset_q),
        .size_i   (size_q),
        .data_o   (lsu_data_o)
    );

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: inputs change 1ns after each rising edge,
// outputs are checked at the following falling edge.
module tb_riscv_lsu;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        lsu_req_i;
    logic        lsu_we_i;
    logic [2:0]  lsu_size_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_data_i;
    logic [31:0] lsu_data_o;
    logic        lsu_stall_req_o;
    logic        lsu_err_o;
    logic        data_req_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic        data_gnt_i;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    riscv_lsu dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .lsu_req_i       (lsu_req_i),
        .lsu_we_i        (lsu_we_i),
        .lsu_size_i      (lsu_size_i),
        .lsu_addr_i      (lsu_addr_i),
        .lsu_data_i      (lsu_data_i),
        .lsu_data_o      (lsu_data_o),
        .lsu_stall_req_o (lsu_stall_req_o),
        .lsu_err_o       (lsu_err_o),
        .data_req_o      (data_req_o),
        .data_we_o       (data_we_o),
        .data_be_o       (data_be_o),
        .data_addr_o     (data_addr_o),
        .data_wdata_o    (data_wdata_o),
        .data_gnt_i      (data_gnt_i),
        .data_rvalid_i   (data_rvalid_i),
        .data_rdata_i    (data_rdata_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic core(input logic req, input logic we, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] wdat);
        lsu_req_i  = req;
        lsu_we_i   = we;
        lsu_size_i = size;
        lsu_addr_i = addr;
        lsu_data_i = wdat;
    endtask

    task automatic mem(input logic gnt, input logic rvalid, input logic [31:0] rdata);
        data_gnt_i    = gnt;
        data_rvalid_i = rvalid;
        data_rdata_i  = rdata;
    endtask

    initial begin
        rst_i = 1'b1;
        core(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        mem(1'b0, 1'b0, 32'h0);

        // Reset: misaligned request while reset is held must not fault or issue.
        next_cycle();
        core(1'b1, 1'b0, 3'd2, 32'h0000_0101, 32'h0);
        #4;
        chk("rst_req", data_req_o, 0);
        chk("rst_err", lsu_err_o, 0);
        chk("rst_stall", lsu_stall_req_o, 1);

        next_cycle();
        rst_i = 1'b0;
        core(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        #4;
        chk("idle_req", data_req_o, 0);
        chk("idle_stall", lsu_stall_req_o, 0);

        // LW 0x100, gnt in issue cycle, rvalid next cycle.
        next_cycle();
        core(1'b1, 1'b0, 3'd2, 32'h0000_0100, 32'h0);
        mem(1'b1, 1'b0, 32'h0);
        #4;
        chk("lw_req", data_req_o, 1);
        chk("lw_be", data_be_o, 4'b1111);
        chk("lw_addr", data_addr_o, 32'h0000_0100);
        chk("lw_we", data_we_o, 0);
        chk("lw_stall1", lsu_stall_req_o, 1);
        next_cycle();
        mem(1'b0, 1'b1, 32'hDEAD_BEEF);
        #4;
        chk("lw_req_wait", data_req_o, 0);
        chk("lw_stall0", lsu_stall_req_o, 0);
        chk("lw_data", lsu_data_o, 32'hDEAD_BEEF);

        // LB 0x103 back-to-back with the previous completion.
        next_cycle();
        core(1'b1, 1'b0, 3'd0, 32'h0000_0103, 32'h0);
        mem(1'b1, 1'b0, 32'h0);
        #4;
        chk("lb_req", data_req_o, 1);
        chk("lb_be", data_be_o, 4'b1000);
        chk("lb_addr", data_addr_o, 32'h0000_0100);
        next_cycle();
        mem(1'b0, 1'b1, 32'h80FF_FFFF);
        #4;
        chk("lb_data", lsu_data_o, 32'hFFFF_FF80);
        chk("lb_stall0", lsu_stall_req_o, 0);

        // LBU 0x103.
        next_cycle();
        core(1'b1, 1'b0, 3'd4, 32'h0000_0103, 32'h0);
        mem(1'b1, 1'b0, 32'h0);
        #4;
        chk("lbu_req", data_req_o, 1);
        next_cycle();
        mem(1'b0, 1'b1, 32'h80FF_FFFF);
        #4;
        chk("lbu_data", lsu_data_o, 32'h0000_0080);

        // LHU 0x206 takes the upper halfword, zero-extended.
        next_cycle();
        core(1'b1, 1'b0, 3'd5, 32'h0000_0206, 32'h0);
        mem(1'b1, 1'b0, 32'h0);
        #4;
        chk("lhu_be", data_be_o, 4'b1100);
        next_cycle();
        mem(1'b0, 1'b1, 32'h8001_7FFF);
        #4;
        chk("lhu_data", lsu_data_o, 32'h0000_8001);

        // LH 0x206 sign-extends the upper halfword.
        next_cycle();
        core(1'b1, 1'b0, 3'd1, 32'h0000_0206, 32'h0);
        mem(1'b1, 1'b0, 32'h0);
        #4;
        next_cycle();
        mem(1'b0, 1'b1, 32'h8001_7FFF);
        #4;
        chk("lh_hi_data", lsu_data_o, 32'hFFFF_8001);

        // LH 0x204 takes the lower halfword.
        next_cycle();
        core(1'b1, 1'b0, 3'd1, 32'h0000_0204, 32'h0);
        mem(1'b1, 1'b0, 32'h0);
        #4;
        chk("lh_lo_be", data_be_o, 4'b0011);
        next_cycle();
        mem(1'b0, 1'b1, 32'h8001_7FFF);
        #4;
        chk("lh_lo_data", lsu_data_o, 32'h0000_7FFF);

        // SH 0x202 with grant held off for three cycles; stray rvalid in WAIT_GNT.
        next_cycle();
        core(1'b1, 1'b1, 3'd1, 32'h0000_0202, 32'h1234_ABCD);
        mem(1'b0, 1'b0, 32'h0);
        #4;
        chk("sh_req0", data_req_o, 1);
        chk("sh_be", data_be_o, 4'b1100);
        chk("sh_wdata", data_wdata_o, 32'hABCD_ABCD);
        chk("sh_addr", data_addr_o, 32'h0000_0200);
        chk("sh_we", data_we_o, 1);
        next_cycle();
        mem(1'b0, 1'b1, 32'h0);
        #4;
        chk("sh_req1", data_req_o, 1);
        chk("sh_stray_rvalid_stall", lsu_stall_req_o, 1);
        next_cycle();
        mem(1'b0, 1'b0, 32'h0);
        #4;
        chk("sh_req2", data_req_o, 1);
        next_cycle();
        mem(1'b1, 1'b0, 32'h0);
        #4;
        chk("sh_req_gnt", data_req_o, 1);
        chk("sh_stall_gnt", lsu_stall_req_o, 1);
        next_cycle();
        mem(1'b0, 1'b0, 32'h0);
        #4;
        chk("sh_req_wait", data_req_o, 0);
        chk("sh_stall_wait", lsu_stall_req_o, 1);
        next_cycle();
        mem(1'b0, 1'b1, 32'h0);
        #4;
        chk("sh_stall_done", lsu_stall_req_o, 0);

        // SB 0x101 replicates the byte and enables lane 1.
        next_cycle();
        core(1'b1, 1'b1, 3'd0, 32'h0000_0101, 32'h0000_00EF);
        mem(1'b1, 1'b0, 32'h0);
        #4;
        chk("sb_be", data_be_o, 4'b0010);
        chk("sb_wdata", data_wdata_o, 32'hEFEF_EFEF);
        next_cycle();
        mem(1'b0, 1'b1, 32'h0);
        #4;
        chk("sb_stall_done", lsu_stall_req_o, 0);

        // Misaligned LW 0x101: one-cycle error, nothing issued.
        next_cycle();
        core(1'b1, 1'b0, 3'd2, 32'h0000_0101, 32'h0);
        mem(1'b1, 1'b0, 32'h0);
        #4;
        chk("mis_err", lsu_err_o, 1);
        chk("mis_req", data_req_o, 0);
        chk("mis_stall", lsu_stall_req_o, 0);
        next_cycle();
        core(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        mem(1'b0, 1'b0, 32'h0);
        #4;
        chk("mis_err_pulse", lsu_err_o, 0);

        // Misaligned halfword and an undefined size code.
        next_cycle();
        core(1'b1, 1'b0, 3'd5, 32'h0000_0103, 32'h0);
        #4;
        chk("mis_hu_err", lsu_err_o, 1);
        next_cycle();
        core(1'b1, 1'b0, 3'd3, 32'h0000_0100, 32'h0);
        mem(1'b1, 1'b0, 32'h0);
        #4;
        chk("bad_size_err", lsu_err_o, 1);
        chk("bad_size_req", data_req_o, 0);

        // Reset while waiting for rvalid; the late rvalid must be ignored.
        next_cycle();
        core(1'b1, 1'b0, 3'd2, 32'h0000_0300, 32'h0);
        mem(1'b1, 1'b0, 32'h0);
        #4;
        chk("rstmid_issue", data_req_o, 1);
        next_cycle();
        rst_i = 1'b1;
        mem(1'b0, 1'b0, 32'h0);
        #4;
        chk("rstmid_req", data_req_o, 0);
        chk("rstmid_stall", lsu_stall_req_o, 1);
        next_cycle();
        rst_i = 1'b0;
        core(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        mem(1'b0, 1'b1, 32'h1111_1111);
        #4;
        chk("late_rvalid_req", data_req_o, 0);
        next_cycle();
        core(1'b1, 1'b0, 3'd2, 32'h0000_0300, 32'h0);
        mem(1'b0, 1'b1, 32'h2222_2222);
        #4;
        chk("post_rst_idle_req", data_req_o, 1);
        chk("post_rst_idle_stall", lsu_stall_req_o, 1);
        next_cycle();
        mem(1'b1, 1'b0, 32'h0);
        #4;
        chk("post_rst_gnt_req", data_req_o, 1);
        next_cycle();
        mem(1'b0, 1'b1, 32'h0BAD_F00D);
        #4;
        chk("post_rst_data", lsu_data_o, 32'h0BAD_F00D);
        chk("post_rst_stall0", lsu_stall_req_o, 0);

        next_cycle();
        core(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        mem(1'b0, 1'b0, 32'h0);
        #4;
        chk("final_idle_req", data_req_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/riscv_lsu.md
RISCV_LSU -- requirements
Module: riscv_lsu

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; all state updates on the rising edge of clk_i.
REQ-002 SHALL expose ports (name  direction  width  meaning):
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- lsu_req_i  in  1  core memory request (decoder mem_req_o)
- lsu_we_i  in  1  1=store, 0=load
- lsu_size_i  in  3  LDST size code (B=0, H=1, W=2, BU=4, HU=5)
- lsu_addr_i  in  32  byte address (ALU result)
- lsu_data_i  in  32  store data (rs2)
- lsu_data_o  out  32  aligned, extended load data
- lsu_stall_req_o  out  1  hold PC/writeback (to decoder lsu_stall_req_i)
- lsu_err_o  out  1  misaligned or bad-size access, one-cycle pulse
- data_req_o  out  1  memory request
- data_we_o  out  1  memory write enable
- data_be_o  out  4  byte enables
- data_addr_o  out  32  word address, bits [1:0]=0
- data_wdata_o  out  32  lane-replicated store data
- data_gnt_i  in  1  memory accepted request
- data_rvalid_i  in  1  response valid (load data or store ack)
- data_rdata_i  in  32  memory read word

Function
REQ-003 SHALL implement FSM states IDLE, WAIT_GNT, WAIT_RVALID.
REQ-004 IDLE: lsu_req_i & !err & data_gnt_i -> WAIT_RVALID; lsu_req_i & !err & !data_gnt_i -> WAIT_GNT; else stay.
REQ-005 WAIT_GNT: data_gnt_i -> WAIT_RVALID; else stay.
REQ-006 WAIT_RVALID: data_rvalid_i -> IDLE; else stay.
REQ-007 data_req_o SHALL be 1 when (IDLE & lsu_req_i & !err) or WAIT_GNT; 0 otherwise.
REQ-008 data_we_o, data_addr_o, data_be_o, data_wdata_o SHALL derive combinationally from core inputs (held stable by the stall).
REQ-009 lsu_stall_req_o SHALL equal lsu_req_i & !err & !(WAIT_RVALID & data_rvalid_i); completion cycle has stall=0.
REQ-010 Minimum latency: 2 cycles (issue with gnt in cycle N, rvalid in N+1, stall low in N+1).
REQ-011 Misaligned: H/HU with addr[0]=1, W with addr[1:0]!=0, or size in {3,6,7} SHALL give err=1, no data_req_o, stall=0, FSM stays IDLE.
REQ-012 data_be_o: B/BU = 0001<<addr[1:0]; H/HU = 0011<<{addr[1],0}; W = 1111.
REQ-013 data_wdata_o: B = byte replicated x4; H = halfword replicated x2; W = lsu_data_i.
REQ-014 Byte offset and size SHALL be latched at issue (request accepted by data_gnt_i) and used for load extraction.
REQ-015 lsu_data_o SHALL be combinational from data_rdata_i: B sign-extends the selected byte, BU zero-extends it, H/HU likewise for the selected halfword, W passes through; value valid in the rvalid cycle, don't-care otherwise.
REQ-016 Store completes on data_rvalid_i; lsu_data_o is unused for stores.
REQ-017 data_rvalid_i in IDLE or WAIT_GNT SHALL be ignored.
REQ-018 Back-to-back accesses: a new lsu_req_i in the cycle after completion SHALL start a fresh transaction from IDLE.

Reset
REQ-019 rst_i SHALL force IDLE and clear the latched offset/size; during reset data_req_o=0, lsu_err_o=0, lsu_stall_req_o=lsu_req_i.
REQ-020 Reset mid-transaction SHALL abandon the access; a late rvalid after reset is ignored per REQ-017.

Structure
REQ-021 LDST size codes SHALL reuse the existing shared defines; the FSM state enum SHALL reside in package riscv_lsu_pkg.
REQ-022 Load extraction SHALL be one sub-module, riscv_lsu_rdata_align (inputs: rdata, offset, size; output: data).

Verification
REQ-023 LW addr 0x100, gnt same cycle, rvalid next cycle with rdata 0xDEADBEEF -> be=1111, addr 0x100, stall 1 then 0, lsu_data_o 0xDEADBEEF.
REQ-024 LB addr 0x103, rdata 0x80FF_FFFF -> be=1000, lsu_data_o 0xFFFFFF80; LBU -> 0x00000080.
REQ-025 SH addr 0x202, data 0x1234ABCD, gnt delayed 3 cycles -> WAIT_GNT held, data_req_o held 1, be=1100, wdata 0xABCDABCD, stall released on rvalid.
REQ-026 LW addr 0x101 -> lsu_err_o=1 for one cycle, data_req_o=0, stall=0.
REQ-027 Reset asserted in WAIT_RVALID, rvalid arrives the next cycle -> FSM in IDLE, response ignored, data_req_o=0.
